// File: rtl/ffd_checker.sv
// ============================================================================
// ffd_checker -- compares a flop's q against d delayed by LATENCY cycles
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module ffd_checker #(
   parameter int WIDTH   = 1,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
) (
   input  logic             aclk,
   input  logic             srst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_checks,
   input  logic             abort,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             last_status,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [CNT_W-1:0] rpt_checks,
   output logic [CNT_W-1:0] rpt_errors
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PRIME  = 2'd1,
      ST_CHECK  = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pipe_q [LATENCY];
   logic [WIDTH-1:0] pipe_d [LATENCY];
   logic [3:0]       prime_cnt_q, prime_cnt_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] checks_q, checks_d;
   logic [CNT_W-1:0] errors_q, errors_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic             mismatch;

   always_comb begin
      state_d     = state_q;
      pipe_d      = pipe_q;
      prime_cnt_d = prime_cnt_q;
      target_d    = target_q;
      checks_d    = checks_q;
      errors_d    = errors_q;
      last_d      = last_q;
      // Case inequality: any X/Z on q is a miscompare.
      mismatch    = (q !== pipe_q[LATENCY-1]);

      if (state_q == ST_PRIME || state_q == ST_CHECK) begin
         pipe_d[0] = d;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               checks_d = '0;
               errors_d = '0;
               if (num_checks == '0) begin
                  state_d = ST_REPORT;
               end else begin
                  target_d    = num_checks;
                  prime_cnt_d = 4'd0;
                  state_d     = ST_PRIME;
               end
            end
         end
         ST_PRIME: begin
            if (prime_cnt_q == 4'(LATENCY-1)) begin
               state_d = ST_CHECK;
            end else begin
               prime_cnt_d = prime_cnt_q + 4'd1;
            end
         end
         ST_CHECK: begin
            checks_d = checks_q + CNT_W'(1);
            if (mismatch) begin
               last_d = 1'b1;
               if (errors_q != '1) begin
                  errors_d = errors_q + CNT_W'(1);
               end
            end else begin
               last_d = 1'b0;
            end
            if (checks_d == target_q) begin
               state_d = ST_REPORT;
            end
         end
         ST_REPORT: begin
            if (rpt_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort) begin
         state_d     = ST_IDLE;
         checks_d    = '0;
         errors_d    = '0;
         last_d      = 1'b0;
         prime_cnt_d = 4'd0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_d[i] = '0;
         end
      end

      busy_d  = (state_d != ST_IDLE);
      valid_d = (state_d == ST_REPORT);
   end

   always_ff @(posedge aclk) begin
      if (srst) begin
         state_q     <= ST_IDLE;
         prime_cnt_q <= 4'd0;
         target_q    <= '0;
         checks_q    <= '0;
         errors_q    <= '0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         prime_cnt_q <= prime_cnt_d;
         target_q    <= target_d;
         checks_q    <= checks_d;
         errors_q    <= errors_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign busy        = busy_q;
   assign last_status = last_q;
   assign rpt_valid   = valid_q;
   assign rpt_checks  = checks_q;
   assign rpt_errors  = errors_q;

endmodule

`default_nettype wire
